// File: rtl/ahbl_subordinate_if_pkg.sv
// ahbl_common: shared AHB-Lite encodings and the subordinate state type.
// Contents:
//   HTRANS_*      transfer type encodings
//   HRESP_*       response encodings
//   HSIZE_*       transfer size encodings
//   sub_state_e   subordinate data-phase state
package ahbl_common;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HWORD = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP,
    ST_ERR1,
    ST_ERR2
  } sub_state_e;

endpackage

// File: rtl/ahbl_subordinate_if_if.sv
// ahbl_bus_if: AHB-Lite bundle between the bus mux and one subordinate.
// Signals:
//   HSEL..HWDATA             driven by the mux side (master modport)
//   HRDATA/HREADYOUT/HRESP   driven by the subordinate (slave modport)
interface ahbl_bus_if #(
  parameter int DW = 32
);
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [2:0]    HBURST;
  logic          HMASTLOCK;
  logic [3:0]    HPROT;
  logic [2:0]    HSIZE;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic          HREADY;
  logic [DW-1:0] HWDATA;
  logic [DW-1:0] HRDATA;
  logic          HREADYOUT;
  logic          HRESP;

  modport master (
    output HSEL, HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWRITE,
           HREADY, HWDATA,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWRITE,
           HREADY, HWDATA,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahbl_subordinate_if_wstrb_gen.sv
// ahbl_wstrb_gen: byte-lane strobes and legality for one AHB transfer.
// Ports:
//   i_size     HSIZE of the transfer
//   i_addr_lo  low address bits selecting the byte lane
//   o_wstrb    2^size ones starting at lane i_addr_lo (zero when illegal)
//   o_illegal  size wider than the bus, or address not size-aligned
module ahbl_wstrb_gen #(
  parameter int DW = 32
) (
  input  logic [2:0]                 i_size,
  input  logic [$clog2(DW/8)-1:0]    i_addr_lo,
  output logic [DW/8-1:0]            o_wstrb,
  output logic                       o_illegal
);
  localparam int NB = DW / 8;
  localparam int AW = $clog2(NB);

  logic          w_oversize;
  logic [AW-1:0] w_align_mask;

  assign w_oversize   = (i_size > 3'(AW));
  assign w_align_mask = AW'((32'd1 << i_size) - 32'd1);
  assign o_illegal    = w_oversize || ((i_addr_lo & w_align_mask) != '0);

  // A lane is covered when it falls in the same 2^size-byte block as the
  // address; with an aligned address that is exactly the transferred bytes.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    localparam logic [AW-1:0] LANE = AW'(gi);
    assign o_wstrb[gi] = !o_illegal && ((LANE >> i_size) == (i_addr_lo >> i_size));
  end
endmodule

// File: rtl/ahbl_subordinate_if.sv
// ahbl_subordinate_if: AHB-Lite subordinate front-end driving a req/ack backend.
// Ports:
//   HCLK, HRESET       clock, asynchronous active-high reset
//   ahb                AHB-Lite bundle (slave side)
//   bk_req..bk_prot    registered backend request and control
//   bk_wdata           HWDATA passed straight through
//   bk_rdata/ack/err   backend completion
module ahbl_subordinate_if
  import ahbl_common::*;
#(
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            HCLK,
  input  logic            HRESET,
  ahbl_bus_if.slave       ahb,
  output logic            bk_req,
  output logic            bk_write,
  output logic [31:0]     bk_addr,
  output logic [DW-1:0]   bk_wdata,
  output logic [DW/8-1:0] bk_wstrb,
  output logic [3:0]      bk_prot,
  input  logic [DW-1:0]   bk_rdata,
  input  logic            bk_ack,
  input  logic            bk_err
);
  localparam int AW = $clog2(DW/8);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  sub_state_e       r_state, w_state_next;
  logic [31:0]      r_addr;
  logic             r_write;
  logic [DW/8-1:0]  r_wstrb;
  logic [3:0]       r_prot;
  logic [CW-1:0]    r_cnt;
  logic [DW-1:0]    r_rdata;

  logic             w_accept, w_illegal, w_load, w_cap;
  logic [DW/8-1:0]  w_wstrb;

  ahbl_wstrb_gen #(.DW(DW)) u_wstrb_gen (
    .i_size    (ahb.HSIZE),
    .i_addr_lo (ahb.HADDR[AW-1:0]),
    .o_wstrb   (w_wstrb),
    .o_illegal (w_illegal)
  );

  // NONSEQ and SEQ both have HTRANS[1] set; IDLE/BUSY never start a data phase.
  assign w_accept = ahb.HSEL && ahb.HREADY && ahb.HTRANS[1];

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_load        = 1'b0;
    w_cap         = 1'b0;
    bk_req        = 1'b0;
    ahb.HREADYOUT = 1'b1;
    ahb.HRESP     = HRESP_OKAY;
    case (r_state)
      ST_IDLE, ST_RESP, ST_ERR2: begin
        if (r_state == ST_ERR2) ahb.HRESP = HRESP_ERROR;
        // Accept is evaluated identically in all ready states so that a new
        // address phase overlapping the last data phase is pipelined.
        if (w_accept) begin
          if (w_illegal) begin
            w_state_next = ST_ERR1;
          end else begin
            w_state_next = ST_ACCESS;
            w_load       = 1'b1;
          end
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        bk_req        = 1'b1;
        ahb.HREADYOUT = 1'b0;
        if (bk_ack) begin
          if (bk_err) begin
            w_state_next = ST_ERR1;
          end else begin
            w_state_next = ST_RESP;
            w_cap        = !r_write;
          end
        end else if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
          w_state_next = ST_ERR1;
        end
      end
      ST_ERR1: begin
        ahb.HREADYOUT = 1'b0;
        ahb.HRESP     = HRESP_ERROR;
        w_state_next  = ST_ERR2;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wstrb <= '0;
      r_prot  <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
    end else begin
      if (w_load) begin
        r_addr  <= ahb.HADDR;
        r_write <= ahb.HWRITE;
        r_wstrb <= ahb.HWRITE ? w_wstrb : '0;
        r_prot  <= ahb.HPROT;
        r_cnt   <= '0;
      end else if (r_state == ST_ACCESS) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_cap) r_rdata <= bk_rdata;
    end
  end

  assign ahb.HRDATA = r_rdata;
  assign bk_write   = r_write;
  assign bk_addr    = r_addr;
  assign bk_wstrb   = r_wstrb;
  assign bk_prot    = r_prot;
  assign bk_wdata   = ahb.HWDATA;
endmodule

// File: tb/tb_ahbl_subordinate_if.sv
module tb_ahbl_subordinate_if;
  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        bk_req, bk_write;
  logic [31:0] bk_addr, bk_wdata, bk_rdata;
  logic [3:0]  bk_wstrb, bk_prot;
  logic        bk_ack, bk_err;

  int n_vec = 0;
  int n_err = 0;

  ahbl_bus_if #(.DW(32)) bus ();

  ahbl_subordinate_if #(.DW(32), .TIMEOUT(4)) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .ahb      (bus),
    .bk_req   (bk_req),
    .bk_write (bk_write),
    .bk_addr  (bk_addr),
    .bk_wdata (bk_wdata),
    .bk_wstrb (bk_wstrb),
    .bk_prot  (bk_prot),
    .bk_rdata (bk_rdata),
    .bk_ack   (bk_ack),
    .bk_err   (bk_err)
  );

  // Single subordinate on the bus: the mux returns our own HREADYOUT.
  assign bus.HREADY = bus.HREADYOUT;

  always #5 HCLK = ~HCLK;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, act);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic [2:0] s, input logic w,
                            input logic [3:0] p);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = a;
    bus.HSIZE = s; bus.HWRITE = w; bus.HPROT = p;
    tick();
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
  endtask

  // Runs from the first data-phase cycle until HREADYOUT returns high.
  // ack_at: ACCESS cycle index carrying bk_ack (-1 = never).
  task automatic data_phase(input int ack_at, input logic [31:0] rdata, input logic err,
                            output int low, output int reqc);
    low = 0; reqc = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.HREADYOUT) break;
      low++;
      if (bk_req) reqc++;
      bk_ack = (i == ack_at); bk_rdata = rdata; bk_err = err;
      tick();
    end
    bk_ack = 1'b0; bk_err = 1'b0;
  endtask

  int low, reqc;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.HSEL = 0; bus.HADDR = 0; bus.HBURST = 0; bus.HMASTLOCK = 0; bus.HPROT = 0;
    bus.HSIZE = 0; bus.HTRANS = 0; bus.HWRITE = 0; bus.HWDATA = 0;
    bk_rdata = 0; bk_ack = 0; bk_err = 0;
    #2;
    check_val("rst_hreadyout", bus.HREADYOUT, 1);
    check_val("rst_hresp", bus.HRESP, 0);
    check_val("rst_hrdata", bus.HRDATA, 0);
    check_val("rst_bk_req", bk_req, 0);
    check_val("rst_bk_wstrb", bk_wstrb, 0);
    tick(); tick();
    HRESET = 1'b0;
    tick();

    // Selected IDLE transfer: zero-wait OKAY, no backend activity.
    bus.HSEL = 1'b1; bus.HTRANS = 2'b00; bus.HADDR = 32'h10;
    tick();
    check_val("idle_bk_req", bk_req, 0);
    check_val("idle_hreadyout", bus.HREADYOUT, 1);
    bus.HSEL = 1'b0;

    // Word write, ack in first ACCESS cycle.
    addr_phase(32'h104, 3'd2, 1'b1, 4'h3);
    bus.HWDATA = 32'hDEADBEEF;
    check_val("wr_bk_req", bk_req, 1);
    check_val("wr_bk_addr", bk_addr, 32'h104);
    check_val("wr_bk_wstrb", bk_wstrb, 4'hF);
    check_val("wr_bk_write", bk_write, 1);
    check_val("wr_bk_prot", bk_prot, 4'h3);
    check_val("wr_bk_wdata", bk_wdata, 32'hDEADBEEF);
    data_phase(0, 32'h55555555, 1'b0, low, reqc);
    check_val("wr_wait_cycles", low, 1);
    check_val("wr_hresp", bus.HRESP, 0);
    check_val("wr_resp_bk_req", bk_req, 0);
    check_val("wr_hrdata_held", bus.HRDATA, 0);
    tick();

    // Byte read at 0x3, ack in third ACCESS cycle.
    addr_phase(32'h3, 3'd0, 1'b0, 4'h0);
    check_val("rdb_bk_wstrb", bk_wstrb, 0);
    check_val("rdb_bk_write", bk_write, 0);
    data_phase(2, 32'hAB000000, 1'b0, low, reqc);
    check_val("rdb_wait_cycles", low, 3);
    check_val("rdb_hrdata", bus.HRDATA, 32'hAB000000);
    check_val("rdb_hreadyout", bus.HREADYOUT, 1);
    check_val("rdb_hresp", bus.HRESP, 0);
    tick();

    // Misaligned halfword: two-cycle ERROR without backend request.
    addr_phase(32'h1, 3'd1, 1'b0, 4'h0);
    check_val("mis_err1_hresp", bus.HRESP, 1);
    check_val("mis_err1_hreadyout", bus.HREADYOUT, 0);
    check_val("mis_err1_bk_req", bk_req, 0);
    tick();
    check_val("mis_err2_hresp", bus.HRESP, 1);
    check_val("mis_err2_hreadyout", bus.HREADYOUT, 1);
    check_val("mis_err2_bk_req", bk_req, 0);
    tick();
    check_val("mis_idle_hresp", bus.HRESP, 0);
    check_val("mis_idle_hreadyout", bus.HREADYOUT, 1);

    // Oversize (doubleword on a 32-bit bus) is illegal.
    addr_phase(32'h8, 3'd3, 1'b1, 4'h0);
    check_val("ovs_hresp", bus.HRESP, 1);
    check_val("ovs_bk_req", bk_req, 0);
    tick(); tick();

    // Halfword write at 0x2 (upper lanes), backend answers with error.
    addr_phase(32'h2, 3'd1, 1'b1, 4'h0);
    check_val("hw_bk_wstrb", bk_wstrb, 4'hC);
    data_phase(0, 32'h0, 1'b1, low, reqc);
    check_val("bkerr_low_cycles", low, 2);
    check_val("bkerr_req_cycles", reqc, 1);
    check_val("bkerr_err2_hresp", bus.HRESP, 1);
    tick();

    // Timeout (TIMEOUT=4): no ack ever.
    addr_phase(32'h20, 3'd2, 1'b0, 4'h0);
    data_phase(-1, 32'h0, 1'b0, low, reqc);
    check_val("to_req_cycles", reqc, 4);
    check_val("to_low_cycles", low, 5);
    check_val("to_err2_hresp", bus.HRESP, 1);
    check_val("to_err2_bk_req", bk_req, 0);
    tick();
    bk_ack = 1'b1; bk_rdata = 32'hFFFFFFFF;
    tick();
    check_val("to_stray_ack_bk_req", bk_req, 0);
    check_val("to_stray_ack_hreadyout", bus.HREADYOUT, 1);
    check_val("to_stray_ack_hrdata", bus.HRDATA, 32'hAB000000);
    bk_ack = 1'b0;
    tick();

    // Back-to-back writes, second address phase in the RESP cycle.
    addr_phase(32'h0, 3'd2, 1'b1, 4'h0);
    bus.HWDATA = 32'h11111111;
    check_val("b2b0_bk_addr", bk_addr, 32'h0);
    check_val("b2b0_bk_wstrb", bk_wstrb, 4'hF);
    bk_ack = 1'b1;
    tick();
    bk_ack = 1'b0;
    check_val("b2b_resp_hreadyout", bus.HREADYOUT, 1);
    check_val("b2b_resp_bk_req", bk_req, 0);
    addr_phase(32'h4, 3'd2, 1'b1, 4'h0);
    bus.HWDATA = 32'h22222222;
    check_val("b2b1_bk_req", bk_req, 1);
    check_val("b2b1_bk_addr", bk_addr, 32'h4);
    check_val("b2b1_bk_wstrb", bk_wstrb, 4'hF);
    check_val("b2b1_hreadyout", bus.HREADYOUT, 0);
    data_phase(0, 32'h0, 1'b0, low, reqc);
    check_val("b2b1_wait_cycles", low, 1);
    tick();

    // Reset in the middle of an access.
    addr_phase(32'h40, 3'd2, 1'b0, 4'h0);
    check_val("rstmid_pre_bk_req", bk_req, 1);
    #2 HRESET = 1'b1;
    #1;
    check_val("rstmid_bk_req", bk_req, 0);
    check_val("rstmid_hreadyout", bus.HREADYOUT, 1);
    check_val("rstmid_hrdata", bus.HRDATA, 0);
    check_val("rstmid_bk_addr", bk_addr, 0);
    tick();
    HRESET = 1'b0;
    tick();
    addr_phase(32'h8, 3'd2, 1'b0, 4'h0);
    check_val("post_rst_bk_addr", bk_addr, 32'h8);
    data_phase(0, 32'h12345678, 1'b0, low, reqc);
    check_val("post_rst_wait_cycles", low, 1);
    check_val("post_rst_hrdata", bus.HRDATA, 32'h12345678);
    check_val("post_rst_hresp", bus.HRESP, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
